m2vside3: RTL and testbench

Stage-3 side information sequencer for the MPEG2 video decoder. It accepts one macroblock descriptor per macroblock from the header parser over a valid/ready handshake. It then presents that macroblock's six 4:2:0 blocks one at a time on the `s3_*` outputs, advancing on each `block_start` pulse. It sits directly upstream of the stage-4 side container, which latches `s3_*` on the same `block_start` edge.

---
 rtl/m2v_pkg.sv | 25 ++
 rtl/m2vside3_if.sv | 34 +++
 rtl/m2vside_buf.sv | 82 ++++++++
 rtl/m2vside3.sv | 90 +++++++++
 tb/tb_m2vside3.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m2v_pkg.sv
// Shared MPEG2 decoder definitions: per-macroblock constants, the macroblock
// descriptor record and the block "coded" helper.
// Descriptor coordinates are carried at M2V_MB_COORD_W bits; users zero-extend.
package m2v_pkg;

  localparam int M2V_BLOCKS_PER_MB = 6;
  localparam int M2V_CBP_WIDTH     = 6;
  localparam int M2V_MB_COORD_W    = 16;

  // One macroblock as delivered by the header parser.
  typedef struct packed {
    logic [M2V_MB_COORD_W-1:0] x;
    logic [M2V_MB_COORD_W-1:0] y;
    logic                      intra;
    logic [M2V_CBP_WIDTH-1:0]  cbp;
  } m2v_mb_desc_t;

  // cbp is MSB-first: bit 5 belongs to block 0. Intra blocks are always coded.
  function automatic logic m2v_block_coded(input logic                     intra,
                                           input logic [M2V_CBP_WIDTH-1:0] cbp,
                                           input logic [2:0]               blk);
    return intra | cbp[3'(M2V_BLOCKS_PER_MB - 1) - blk];
  endfunction

endpackage

// File: rtl/m2vside3_if.sv
// Stage-3 side-info bus: descriptor input handshake (s2_*), flush and block
// advance controls, and the per-block side outputs (s3_*).
// Ports: master = upstream/downstream driver side, slave = the sequencer.
interface m2vside3_if #(
  parameter int MBX_WIDTH = 7,
  parameter int MBY_WIDTH = 7
) ();

  logic                 pic_start;
  logic [MBX_WIDTH-1:0] s2_mb_x;
  logic [MBY_WIDTH-1:0] s2_mb_y;
  logic                 s2_mb_intra;
  logic [5:0]           s2_cbp;
  logic                 s2_valid;
  logic                 s2_ready;
  logic                 block_start;
  logic [MBX_WIDTH-1:0] s3_mb_x;
  logic [MBY_WIDTH-1:0] s3_mb_y;
  logic                 s3_mb_intra;
  logic [2:0]           s3_block;
  logic                 s3_coded;
  logic                 s3_enable;

  modport master (
    output pic_start, s2_mb_x, s2_mb_y, s2_mb_intra, s2_cbp, s2_valid, block_start,
    input  s2_ready, s3_mb_x, s3_mb_y, s3_mb_intra, s3_block, s3_coded, s3_enable
  );

  modport slave (
    input  pic_start, s2_mb_x, s2_mb_y, s2_mb_intra, s2_cbp, s2_valid, block_start,
    output s2_ready, s3_mb_x, s3_mb_y, s3_mb_intra, s3_block, s3_coded, s3_enable
  );

endinterface

// File: rtl/m2vside_buf.sv
// Macroblock descriptor FIFO, depth 1 (holding register) or 2 (shift pair).
// Latency: a push is visible at the head one cycle later.
// Backpressure: o_full depends only on occupancy; a pop never frees space the same cycle.
// Ports: clk, reset_n (async active-low); i_flush clears all entries next cycle and
//        overrides push/pop; i_push/i_push_dat write; i_pop drops the head;
//        o_head_dat is the oldest entry; o_empty/o_full are occupancy flags.
module m2vside_buf
  import m2v_pkg::*;
#(
  parameter int DEPTH = 1  // 1 or 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  m2v_mb_desc_t i_push_dat,
  input  logic         i_pop,
  output m2v_mb_desc_t o_head_dat,
  output logic         o_empty,
  output logic         o_full
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] r_cnt;
  m2v_mb_desc_t  r_slot0;  // always the head entry
  logic          w_push;
  logic          w_pop;

  assign o_empty    = (r_cnt == '0);
  assign o_full     = (r_cnt == CW'(DEPTH));
  assign o_head_dat = r_slot0;

  // Illegal requests are dropped here so the counter can never wrap.
  assign w_push = i_push & ~o_full  & ~i_flush;
  assign w_pop  = i_pop  & ~o_empty & ~i_flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else if (w_push && !w_pop) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_pop && !w_push) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  generate
    if (DEPTH == 2) begin : g_depth2
      m2v_mb_desc_t r_slot1;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_slot0 <= '0;
          r_slot1 <= '0;
        end else begin
          // Push lands in the head slot when the buffer is empty, or when the
          // single held entry is leaving in the same cycle.
          if (w_push && (o_empty || w_pop)) begin
            r_slot0 <= i_push_dat;
          end else if (w_pop && o_full) begin
            r_slot0 <= r_slot1;
          end
          if (w_push && !o_empty && !w_pop) begin
            r_slot1 <= i_push_dat;
          end
        end
      end
    end else begin : g_depth1
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_slot0 <= '0;
        end else if (w_push) begin
          r_slot0 <= i_push_dat;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/m2vside3.sv
// Stage-3 side-info sequencer: expands each macroblock descriptor into six block records.
// Latency: descriptor accepted at edge N is shown as block 0 after edge N; one block per block_start.
// Backpressure: s2_ready = descriptor buffer not full (occupancy only, no combinational path).
// Ports: clk, reset_n (async active-low); bus (m2vside3_if.slave) carrying pic_start,
//        s2_* descriptor handshake, block_start, and s3_* current-block outputs.
// Config macro: M2V_SIDE3_DEPTH2_EN selects a 2-entry descriptor buffer (no bubble
//        between macroblocks); undefined gives a single holding register.
module m2vside3
  import m2v_pkg::*;
#(
  parameter int MBX_WIDTH = 7,
  parameter int MBY_WIDTH = 7
) (
  input  logic           clk,
  input  logic           reset_n,
  m2vside3_if.slave      bus
);

`ifdef M2V_SIDE3_DEPTH2_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif

  localparam logic [2:0] LAST_BLK = 3'(M2V_BLOCKS_PER_MB - 1);

  m2v_mb_desc_t w_push_dat;
  m2v_mb_desc_t w_head;
  logic         w_empty;
  logic         w_full;
  logic         w_push;
  logic         w_pop;
  logic         w_enable;
  logic         w_adv;
  logic         w_unused_coord;
  logic [2:0]   r_blk;

  always_comb begin
    w_push_dat                    = '0;
    w_push_dat.x[MBX_WIDTH-1:0]   = bus.s2_mb_x;
    w_push_dat.y[MBY_WIDTH-1:0]   = bus.s2_mb_y;
    w_push_dat.intra              = bus.s2_mb_intra;
    w_push_dat.cbp                = bus.s2_cbp;
  end

  assign w_enable = ~w_empty;
  // pic_start wins over everything in its cycle: no push, no advance, no pop.
  assign w_push   = bus.s2_valid & ~w_full & ~bus.pic_start;
  assign w_adv    = bus.block_start & w_enable & ~bus.pic_start;
  assign w_pop    = w_adv & (r_blk == LAST_BLK);

  m2vside_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_flush    (bus.pic_start),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  // Block counter. It only moves while a head entry exists, so it is 0
  // whenever the buffer is empty and s3_block needs no extra gating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blk <= '0;
    end else if (bus.pic_start) begin
      r_blk <= '0;
    end else if (w_adv) begin
      r_blk <= (r_blk == LAST_BLK) ? 3'd0 : r_blk + 3'd1;
    end
  end

  assign bus.s2_ready    = ~w_full;
  assign bus.s3_enable   = w_enable;
  assign bus.s3_block    = r_blk;
  assign bus.s3_mb_x     = w_enable ? w_head.x[MBX_WIDTH-1:0] : '0;
  assign bus.s3_mb_y     = w_enable ? w_head.y[MBY_WIDTH-1:0] : '0;
  assign bus.s3_mb_intra = w_enable & w_head.intra;
  assign bus.s3_coded    = w_enable & m2v_block_coded(w_head.intra, w_head.cbp, r_blk);

  // Coordinates are stored at package width; the bits above the configured
  // width are always zero and intentionally go nowhere.
  assign w_unused_coord  = ^{w_head.x >> MBX_WIDTH, w_head.y >> MBY_WIDTH};

endmodule

// File: tb/tb_m2vside3.sv
module tb_m2vside3;

`ifdef M2V_SIDE3_DEPTH2_EN
  localparam int TB_DEPTH = 2;
`else
  localparam int TB_DEPTH = 1;
`endif
  localparam logic RDY1    = (TB_DEPTH == 2);  // ready while one descriptor is held
  localparam int   EXP_GAP = (TB_DEPTH == 2) ? 0 : 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  m2vside3_if #(.MBX_WIDTH(7), .MBY_WIDTH(7)) bus ();

  m2vside3 #(.MBX_WIDTH(7), .MBY_WIDTH(7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] x;
    logic [6:0] y;
    logic       intra;
    logic [5:0] cbp;
  } desc_t;

  typedef struct {
    logic        pic;
    logic        vld;
    desc_t       d;
    logic        bs;
    logic [20:0] exp;
  } vec_t;

  // Reference model: queue of accepted macroblocks plus current block index.
  desc_t mq[$];
  int    m_blk;
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic logic [20:0] mk(input logic en, input logic [2:0] blk, input logic coded,
                                     input logic intra, input logic [6:0] x, input logic [6:0] y,
                                     input logic rdy);
    return {en, blk, coded, intra, x, y, rdy};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {bus.s3_enable, bus.s3_block, bus.s3_coded, bus.s3_mb_intra,
            bus.s3_mb_x, bus.s3_mb_y, bus.s2_ready};
  endfunction

  function automatic logic [20:0] mdl_vec();
    logic       en;
    logic       coded;
    logic [5:0] c;
    desc_t      h;
    en    = (mq.size() > 0);
    coded = 1'b0;
    h     = '{x: 7'd0, y: 7'd0, intra: 1'b0, cbp: 6'd0};
    if (en) begin
      h     = mq[0];
      c     = h.cbp;
      coded = h.intra | c[5 - m_blk];
    end
    return mk(en, 3'(m_blk), coded, h.intra, h.x, h.y, logic'(mq.size() < TB_DEPTH));
  endfunction

  task automatic model_edge();
    int    sz;
    desc_t d;
    if (bus.pic_start) begin
      mq.delete();
      m_blk = 0;
    end else begin
      sz = mq.size();
      if (bus.block_start && sz > 0) begin
        if (m_blk == 5) begin
          void'(mq.pop_front());
          m_blk = 0;
        end else begin
          m_blk++;
        end
      end
      if (bus.s2_valid && sz < TB_DEPTH) begin
        d.x = bus.s2_mb_x; d.y = bus.s2_mb_y; d.intra = bus.s2_mb_intra; d.cbp = bus.s2_cbp;
        mq.push_back(d);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic pic, input logic vld, input desc_t d, input logic bs);
    bus.pic_start   = pic;
    bus.s2_valid    = vld;
    bus.s2_mb_x     = d.x;
    bus.s2_mb_y     = d.y;
    bus.s2_mb_intra = d.intra;
    bus.s2_cbp      = d.cbp;
    bus.block_start = bs;
  endtask

  task automatic check_vec(input string nm, input logic [20:0] act, input logic [20:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got en/blk/coded/intra/x/y/rdy=%h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string nm);
    check_vec(nm, dut_vec(), mdl_vec());
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  vec_t  tv[16];
  logic  obs_en[17];
  logic  acc;
  logic  seen_b;
  logic [6:0] b_x;
  int    first_en, last_en, gap, en_cnt;

  initial begin
    desc_t z, a, in, a2, b2, c1, c2, d1, d2, e1, r;
    z  = '{x: 7'd0,  y: 7'd0,  intra: 1'b0, cbp: 6'b000000};
    a  = '{x: 7'd3,  y: 7'd2,  intra: 1'b0, cbp: 6'b101001};
    in = '{x: 7'd5,  y: 7'd1,  intra: 1'b1, cbp: 6'b000000};
    a2 = '{x: 7'd10, y: 7'd20, intra: 1'b0, cbp: 6'b111111};
    b2 = '{x: 7'd11, y: 7'd21, intra: 1'b1, cbp: 6'b000000};
    c1 = '{x: 7'd1,  y: 7'd1,  intra: 1'b0, cbp: 6'b000001};
    c2 = '{x: 7'd2,  y: 7'd2,  intra: 1'b0, cbp: 6'b100000};
    d1 = '{x: 7'd4,  y: 7'd4,  intra: 1'b0, cbp: 6'b010101};
    d2 = '{x: 7'd6,  y: 7'd6,  intra: 1'b1, cbp: 6'b000000};
    e1 = '{x: 7'd7,  y: 7'd9,  intra: 1'b1, cbp: 6'b110000};

    // Vector table: inputs applied for one edge, outputs checked after it.
    tv[0]  = '{1'b0, 1'b1, a,  1'b0, mk(1'b1, 3'd0, 1'b1, 1'b0, 7'd3, 7'd2, RDY1)};
    tv[1]  = '{1'b0, 1'b0, z,  1'b1, mk(1'b1, 3'd1, 1'b0, 1'b0, 7'd3, 7'd2, RDY1)};
    tv[2]  = '{1'b0, 1'b0, z,  1'b1, mk(1'b1, 3'd2, 1'b1, 1'b0, 7'd3, 7'd2, RDY1)};
    tv[3]  = '{1'b0, 1'b0, z,  1'b1, mk(1'b1, 3'd3, 1'b0, 1'b0, 7'd3, 7'd2, RDY1)};
    tv[4]  = '{1'b0, 1'b0, z,  1'b1, mk(1'b1, 3'd4, 1'b0, 1'b0, 7'd3, 7'd2, RDY1)};
    tv[5]  = '{1'b0, 1'b0, z,  1'b1, mk(1'b1, 3'd5, 1'b1, 1'b0, 7'd3, 7'd2, RDY1)};
    tv[6]  = '{1'b0, 1'b0, z,  1'b1, mk(1'b0, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b1)};
    tv[7]  = '{1'b0, 1'b0, z,  1'b1, mk(1'b0, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b1)};
    tv[8]  = '{1'b0, 1'b1, in, 1'b0, mk(1'b1, 3'd0, 1'b1, 1'b1, 7'd5, 7'd1, RDY1)};
    tv[9]  = '{1'b0, 1'b0, z,  1'b1, mk(1'b1, 3'd1, 1'b1, 1'b1, 7'd5, 7'd1, RDY1)};
    tv[10] = '{1'b0, 1'b0, z,  1'b1, mk(1'b1, 3'd2, 1'b1, 1'b1, 7'd5, 7'd1, RDY1)};
    tv[11] = '{1'b0, 1'b0, z,  1'b1, mk(1'b1, 3'd3, 1'b1, 1'b1, 7'd5, 7'd1, RDY1)};
    tv[12] = '{1'b0, 1'b0, z,  1'b1, mk(1'b1, 3'd4, 1'b1, 1'b1, 7'd5, 7'd1, RDY1)};
    tv[13] = '{1'b0, 1'b0, z,  1'b1, mk(1'b1, 3'd5, 1'b1, 1'b1, 7'd5, 7'd1, RDY1)};
    tv[14] = '{1'b0, 1'b0, z,  1'b1, mk(1'b0, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b1)};
    tv[15] = '{1'b0, 1'b0, z,  1'b0, mk(1'b0, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b1)};

    // Reset
    set_in(1'b0, 1'b0, z, 1'b0);
    mq.delete();
    m_blk = 0;
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_state", dut_vec(), mk(1'b0, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b1));
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_vec("post_reset", dut_vec(), mk(1'b0, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b1));

    // Table-driven: non-intra cbp walk, idle block_start, intra cbp=0
    for (int i = 0; i < 16; i++) begin
      set_in(tv[i].pic, tv[i].vld, tv[i].d, tv[i].bs);
      tick();
      check_vec($sformatf("table_%0d", i), dut_vec(), tv[i].exp);
    end

    // Two descriptors back-to-back, block_start every cycle
    set_in(1'b0, 1'b1, a2, 1'b0);
    tick();
    check_model("b2b_first");
    obs_en[0] = bus.s3_enable;
    seen_b = 1'b0;
    b_x = 7'd0;
    set_in(1'b0, 1'b1, b2, 1'b1);
    for (int i = 0; i < 16; i++) begin
      acc = bus.s2_valid & bus.s2_ready;
      tick();
      if (acc) bus.s2_valid = 1'b0;
      check_model("b2b_cycle");
      obs_en[i+1] = bus.s3_enable;
      if (bus.s3_enable && bus.s3_block == 3'd0 && !seen_b) begin
        seen_b = 1'b1;
        b_x = bus.s3_mb_x;
      end
    end
    first_en = -1; last_en = -1; gap = 0; en_cnt = 0;
    for (int k = 0; k < 17; k++) begin
      if (obs_en[k]) begin
        en_cnt++;
        if (first_en < 0) first_en = k;
        last_en = k;
      end
    end
    if (first_en >= 0) begin
      for (int k = first_en; k <= last_en; k++) if (!obs_en[k]) gap++;
    end
    check_int("b2b_blocks", en_cnt, 12);
    check_int("b2b_gap", gap, EXP_GAP);
    check_int("b2b_second_x", int'(b_x), 11);

    // Push coincident with the block-5 block_start
    set_in(1'b0, 1'b1, c1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, z, 1'b1);
    repeat (5) tick();
    check_model("coinc_blk5");
    set_in(1'b0, 1'b1, c2, 1'b1);
    tick();
    if (TB_DEPTH == 2)
      check_vec("coinc_push", dut_vec(), mk(1'b1, 3'd0, 1'b1, 1'b0, 7'd2, 7'd2, 1'b1));
    else
      check_vec("coinc_push", dut_vec(), mk(1'b0, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b1));
    set_in(1'b0, 1'b0, z, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_model("coinc_drain");
    end

    // pic_start at blk=3 with block_start and a push
    set_in(1'b0, 1'b1, d1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, z, 1'b1);
    repeat (3) tick();
    check_model("pic_blk3");
    set_in(1'b1, 1'b1, d2, 1'b1);
    tick();
    check_vec("pic_flush", dut_vec(), mk(1'b0, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b1));
    set_in(1'b0, 1'b0, z, 1'b0);
    tick();
    check_vec("pic_lost", dut_vec(), mk(1'b0, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b1));

    // Asynchronous reset in the middle of a macroblock (blk=4)
    set_in(1'b0, 1'b1, e1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, z, 1'b1);
    repeat (4) tick();
    check_model("pre_reset_blk4");
    set_in(1'b0, 1'b0, z, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_vec("async_reset", dut_vec(), mk(1'b0, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b1));
    mq.delete();
    m_blk = 0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_model("reset_release");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r.x = 7'($urandom);
      r.y = 7'($urandom);
      r.intra = 1'($urandom_range(0, 3) == 0);
      r.cbp = 6'($urandom);
      set_in(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), r,
             1'($urandom_range(0, 9) < 7));
      tick();
      check_model("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
